// File: rtl/ascon_perm_iter.sv
// ascon_perm_iter: iterative Ascon p12/p8 permutation, UNROLL rounds per clock.
module ascon_perm_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         nr12_i,
    input  logic [319:0] state_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [319:0] state_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         r_fsm;
    logic [3:0]   r_rnd;
    logic [319:0] r_state;
    logic [319:0] w_nxt;
    logic [3:0]   w_rnd_nxt;
    logic         w_last;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] rnd_f(input logic [319:0] s, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [3:0]  j;
        {x0, x1, x2, x3, x4} = s;
        // Round 4 carries constant 0xf0, round 15 carries 0x4b.
        j  = i - 4'd4;
        x2 = x2 ^ {56'd0, ~j, j};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb begin
        w_nxt = r_state;
        for (int k = 0; k < UNROLL; k++) w_nxt = rnd_f(w_nxt, r_rnd + 4'(k));
    end

    // The final slice always ends on round 15, so the round counter wraps to zero.
    assign w_rnd_nxt = r_rnd + 4'(UNROLL);
    assign w_last    = w_rnd_nxt == 4'h0;

    assign ready_o = (r_fsm == IDLE) || (r_fsm == DONE);
    assign busy_o  = r_fsm == RUN;
    assign done_o  = r_fsm == DONE;
    assign state_o = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_rnd   <= 4'h0;
            r_state <= '0;
        end else if (start_i && ready_o) begin
            r_fsm   <= RUN;
            r_rnd   <= nr12_i ? 4'h4 : 4'h8;
            r_state <= state_i;
        end else if (r_fsm == RUN) begin
            r_fsm   <= w_last ? DONE : RUN;
            r_rnd   <= w_rnd_nxt;
            r_state <= w_nxt;
        end else begin
            r_fsm   <= IDLE;
        end
    end
endmodule

// File: tb/tb_ascon_perm_iter.sv
// tb_ascon_perm_iter: scoreboard bench for ascon_perm_iter against a table-driven Ascon model.
module tb_ascon_perm_iter;
    parameter int U = 1;

    logic         clk = 0;
    logic         rst = 1;
    logic         start_i = 0;
    logic         nr12_i = 0;
    logic [319:0] state_i = '0;
    logic         ready_o, busy_o, done_o;
    logic [319:0] state_o;

    ascon_perm_iter #(.UNROLL(U)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .nr12_i(nr12_i), .state_i(state_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [319:0] s;
        int           c;
    } exp_t;

    exp_t         q[$];
    logic [319:0] last_exp = '0;
    int           n_chk = 0;
    int           n_fail = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input logic n12);
        logic [63:0] x [5];
        logic [4:0]  v;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int r = (n12 ? 0 : 4); r < 12; r++) begin
            x[2] = x[2] ^ {56'd0, 8'hf0 - 8'(r) * 8'h0f};
            for (int b = 0; b < 64; b++) begin
                v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = v;
            end
            x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
            x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
            x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
            x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
            x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic chk(input string nm, input logic ok, input logic [319:0] act, input logic [319:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Monitor: samples one time unit after each rising edge and checks against the queue head.
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("idle_flags", {ready_o, busy_o, done_o} == 3'b100, 320'({ready_o, busy_o, done_o}), 320'b100);
            chk("idle_state", state_o == last_exp, state_o, last_exp);
        end else if (cyc < q[0].c) begin
            chk("run_flags", {ready_o, busy_o, done_o} == 3'b010, 320'({ready_o, busy_o, done_o}), 320'b010);
        end else begin
            chk("done_flags", {ready_o, busy_o, done_o} == 3'b101, 320'({ready_o, busy_o, done_o}), 320'b101);
            chk("result", state_o == q[0].s, state_o, q[0].s);
            last_exp = q[0].s;
            void'(q.pop_front());
        end
    end

    task automatic go(input logic n12, input logic [319:0] s);
        int w = 0;
        start_i = 1;
        nr12_i  = n12;
        state_i = s;
        while (!ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", ready_o, 320'(ready_o), 320'd1);
        if (ready_o) q.push_back('{perm(s, n12), cyc + 1 + (n12 ? 12 : 8) / U});
        @(negedge clk);
    endtask

    task automatic drain();
        int w = 0;
        start_i = 0;
        while (q.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain", q.size() == 0, 320'(q.size()), 320'd0);
        @(negedge clk);
    endtask

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        go(1, {64'h9043340012005440, 64'h4925669902022042, 64'h5532006940392211,
               64'h0011134445600600, 64'h1112223333444555});
        drain();
        go(0, '0);
        drain();
        for (int k = 0; k < 6; k++) go(k[0] == 0, rnd320());
        drain();
        go(1, rnd320());
        start_i = 0;
        repeat (4) @(negedge clk);
        start_i = 1;
        nr12_i  = 0;
        state_i = rnd320();
        @(negedge clk);
        drain();
        go(1, rnd320());
        start_i = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        q.delete();
        last_exp = '0;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        go(1, rnd320());
        drain();
        for (int k = 0; k < 8; k++) begin
            go(1'($urandom), rnd320());
            start_i = 0;
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
